// File: rtl/metrics_sequencer.sv
// metrics_sequencer
// Sequences one signal-metrics measurement frame: gates the free-running ADC
// stream into a single frame, triggers the FFT, waits for its last magnitude
// bin, lets the THD scan settle and then issues one result strobe.
// Runs single-shot or continuous, with abort and an FFT watchdog.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  one-cycle request, honoured only in IDLE
//   continuous_i             1: a finished frame re-arms instead of idling
//   abort_i                  forces IDLE from any state, suppresses strobes
//   adc_data_i, adc_valid_i  raw ADC stream
//   magnitude_valid_i/last_i FFT magnitude stream (monitored only)
//   frame_start_o            first sample of a frame (registered)
//   sample_data_o            registered copy of the accepted ADC sample
//   sample_valid_o           frame sample strobe (registered)
//   fft_start_o              one-cycle FFT trigger
//   busy_o                   high whenever the sequencer is not IDLE
//   result_valid_o           one-cycle strobe, metrics outputs are stable
//   timeout_err_o            sticky FFT timeout flag, cleared by start or rst
//   frame_count_o            completed frames, wraps at 16 bits
//
// SETTLE_CYCLES must be at least 2: the DONE cycle counts as the last settle
// cycle so that result_valid lands SETTLE_CYCLES+1 cycles after the cycle that
// sampled magnitude_last, while abort in DONE can still suppress the result.
module metrics_sequencer #(
    parameter int DATA_WIDTH     = 12,
    parameter int SAMPLE_COUNT   = 1024,
    parameter int SETTLE_CYCLES  = 520,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] adc_data_i,
    input  logic                  adc_valid_i,
    input  logic                  magnitude_valid_i,
    input  logic                  magnitude_last_i,
    output logic                  frame_start_o,
    output logic [DATA_WIDTH-1:0] sample_data_o,
    output logic                  sample_valid_o,
    output logic                  fft_start_o,
    output logic                  busy_o,
    output logic                  result_valid_o,
    output logic                  timeout_err_o,
    output logic [15:0]           frame_count_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        CAPTURE  = 3'd2,
        FFT_WAIT = 3'd3,
        SETTLE   = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [31:0] SAMPLE_LAST  = 32'(SAMPLE_COUNT - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    // SETTLE holds SETTLE_CYCLES-1 cycles; DONE supplies the final one.
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 2);

    state_t                  state_q;
    logic                    frame_start_q;
    logic [DATA_WIDTH-1:0]   sample_data_q;
    logic                    sample_valid_q;
    logic                    fft_start_q;
    logic                    fft_pending_q;
    logic                    busy_q;
    logic                    result_valid_q;
    logic                    timeout_err_q;
    logic [15:0]             frame_count_q;
    logic [31:0]             sample_cnt_q;
    logic [15:0]             settle_cnt_q;
    logic [31:0]             timeout_cnt_q;

    // Frame sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            frame_start_q  <= 1'b0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            fft_start_q    <= 1'b0;
            fft_pending_q  <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            frame_count_q  <= 16'd0;
            sample_cnt_q   <= 32'd0;
            settle_cnt_q   <= 16'd0;
            timeout_cnt_q  <= 32'd0;
        end else begin
            // Strobes default low; each state raises only what it owns.
            frame_start_q  <= 1'b0;
            sample_valid_q <= 1'b0;
            fft_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            if (abort_i) begin
                state_q       <= IDLE;
                busy_q        <= 1'b0;
                fft_pending_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q       <= ARM;
                            busy_q        <= 1'b1;
                            timeout_err_q <= 1'b0;
                        end
                    end
                    ARM: begin
                        if (adc_valid_i) begin
                            frame_start_q <= 1'b1;
                            sample_data_q <= adc_data_i;
                            sample_cnt_q  <= 32'd0;
                            state_q       <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (adc_valid_i) begin
                            sample_valid_q <= 1'b1;
                            sample_data_q  <= adc_data_i;
                            if (sample_cnt_q == SAMPLE_LAST) begin
                                state_q       <= FFT_WAIT;
                                fft_pending_q <= 1'b1;
                                timeout_cnt_q <= 32'd0;
                            end else begin
                                sample_cnt_q <= sample_cnt_q + 32'd1;
                            end
                        end
                    end
                    FFT_WAIT: begin
                        // fft_start follows the last sample_valid by one cycle.
                        fft_start_q   <= fft_pending_q;
                        fft_pending_q <= 1'b0;
                        if (magnitude_valid_i && magnitude_last_i) begin
                            state_q      <= SETTLE;
                            settle_cnt_q <= 16'd0;
                        end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                            timeout_err_q <= 1'b1;
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
                        end else begin
                            timeout_cnt_q <= timeout_cnt_q + 32'd1;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= DONE;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 16'd1;
                        end
                    end
                    DONE: begin
                        // Result is committed on leaving DONE so abort here cancels it.
                        result_valid_q <= 1'b1;
                        frame_count_q  <= frame_count_q + 16'd1;
                        state_q        <= continuous_i ? ARM : IDLE;
                        busy_q         <= continuous_i;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign frame_start_o  = frame_start_q;
    assign sample_data_o  = sample_data_q;
    assign sample_valid_o = sample_valid_q;
    assign fft_start_o    = fft_start_q;
    assign busy_o         = busy_q;
    assign result_valid_o = result_valid_q;
    assign timeout_err_o  = timeout_err_q;
    assign frame_count_o  = frame_count_q;

endmodule

// File: tb/tb_metrics_sequencer.sv
// Testbench for metrics_sequencer. Each frame is driven as a procedural
// sequence and every cycle's outputs are predicted from the timing rules.
module tb_metrics_sequencer;

    localparam int DW  = 12;
    localparam int SC  = 8;
    localparam int SET = 10;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          abort;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          mag_valid;
    logic          mag_last;
    logic          frame_start;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          fft_start;
    logic          busy;
    logic          result_valid;
    logic          timeout_err;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    metrics_sequencer #(
        .DATA_WIDTH    (DW),
        .SAMPLE_COUNT  (SC),
        .SETTLE_CYCLES (SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .continuous_i     (continuous),
        .abort_i          (abort),
        .adc_data_i       (adc_data),
        .adc_valid_i      (adc_valid),
        .magnitude_valid_i(mag_valid),
        .magnitude_last_i (mag_last),
        .frame_start_o    (frame_start),
        .sample_data_o    (sample_data),
        .sample_valid_o   (sample_valid),
        .fft_start_o      (fft_start),
        .busy_o           (busy),
        .result_valid_o   (result_valid),
        .timeout_err_o    (timeout_err),
        .frame_count_o    (frame_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Inputs set before the call are sampled by the edge; outputs read after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        start     = 1'b0;
        abort     = 1'b0;
        adc_valid = 1'b0;
        mag_valid = 1'b0;
        mag_last  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_fs"},   frame_start, 0);
        check_eq({tag, "_sd"},   sample_data, 0);
        check_eq({tag, "_sv"},   sample_valid, 0);
        check_eq({tag, "_fft"},  fft_start, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_rv"},   result_valid, 0);
        check_eq({tag, "_to"},   timeout_err, 0);
        check_eq({tag, "_cnt"},  frame_count, 0);
    endtask

    task automatic do_start();
        start     = 1'b1;
        adc_valid = 1'($urandom);
        adc_data  = DW'($urandom);
        step();
        quiet_inputs();
        check_eq("start_busy", busy, 1);
        check_eq("start_to_clr", timeout_err, 0);
        check_eq("start_no_fs", frame_start, 0);
    endtask

    // mode: 0 every cycle, 1 every 3rd cycle, 2 random gaps.
    // abort_k: sample index at which to abort (-1 none); k=0 is frame_start.
    task automatic do_frame(input int mode, input int abort_k, input bit abort_done,
                            input bit rst_settle, input bit expect_timeout);
        int k = 0;
        int c = 0;
        bit v;
        logic [DW-1:0] d;
        int w;
        // capture phase
        while (k <= SC) begin
            v = (mode == 0) || (mode == 1 && (c % 3) == 2) ||
                (mode == 2 && $urandom_range(0, 1) == 0);
            c++;
            d = DW'($urandom);
            adc_valid = v;
            adc_data  = d;
            abort     = v && (k == abort_k);
            start     = !abort && ($urandom_range(0, 7) == 0);
            step();
            if (abort) begin
                quiet_inputs();
                check_eq("abort_fs", frame_start, 0);
                check_eq("abort_sv", sample_valid, 0);
                check_eq("abort_busy", busy, 0);
                for (int i = 0; i < 4; i++) begin
                    adc_valid = 1'b1;
                    step();
                    check_eq("abort_fft", fft_start, 0);
                    check_eq("abort_sv2", sample_valid, 0);
                    check_eq("abort_idle", busy, 0);
                end
                quiet_inputs();
                check_eq("abort_cnt", frame_count, 32'(exp_count));
                return;
            end
            check_eq("cap_fs", frame_start, 32'(v && k == 0));
            check_eq("cap_sv", sample_valid, 32'(v && k > 0));
            check_eq("cap_fft", fft_start, 0);
            check_eq("cap_busy", busy, 1);
            if (v) begin
                check_eq("cap_data", sample_data, 32'(d));
                k++;
            end
        end
        quiet_inputs();
        // FFT wait phase
        if (expect_timeout) begin
            for (int i = 1; i <= TO; i++) begin
                adc_valid = 1'($urandom);
                mag_valid = 1'($urandom);
                step();
                check_eq("to_fft", fft_start, 32'(i == 1));
                check_eq("to_sv", sample_valid, 0);
                check_eq("to_rv", result_valid, 0);
                check_eq("to_err", timeout_err, 32'(i == TO));
                check_eq("to_busy", busy, 32'(i != TO));
            end
            quiet_inputs();
            return;
        end
        w = $urandom_range(0, 20);
        for (int i = 0; i <= w; i++) begin
            adc_valid = 1'($urandom);
            mag_valid = 1'($urandom);
            step();
            check_eq("fw_fft", fft_start, 32'(i == 0));
            check_eq("fw_sv", sample_valid, 0);
            check_eq("fw_rv", result_valid, 0);
        end
        quiet_inputs();
        mag_valid = 1'b1;
        mag_last  = 1'b1;
        step();
        quiet_inputs();
        check_eq("last_rv", result_valid, 0);
        // settle phase: result expected SET+1 cycles after the magnitude_last cycle
        for (int j = 1; j <= SET; j++) begin
            if (rst_settle && j == SET / 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                exp_count = 0;
                check_reset_values("rst_settle");
                return;
            end
            adc_valid = 1'($urandom);
            abort     = abort_done && (j == SET);
            step();
            quiet_inputs();
            check_eq("set_sv", sample_valid, 0);
            if (j < SET) begin
                check_eq("set_rv", result_valid, 0);
                check_eq("set_busy", busy, 1);
            end else if (abort_done) begin
                check_eq("abort_done_rv", result_valid, 0);
                check_eq("abort_done_busy", busy, 0);
                check_eq("abort_done_cnt", frame_count, 32'(exp_count));
            end else begin
                exp_count = (exp_count + 1) % 65536;
                check_eq("done_rv", result_valid, 1);
                check_eq("done_cnt", frame_count, 32'(exp_count));
                check_eq("done_busy", busy, 32'(continuous));
            end
        end
        if (!abort_done) begin
            step();
            check_eq("rv_one_cycle", result_valid, 0);
            check_eq("post_busy", busy, 32'(continuous));
        end
    endtask

    initial begin
        rst        = 1'b1;
        continuous = 1'b0;
        adc_data   = '0;
        quiet_inputs();
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        check_reset_values("idle");

        // inputs other than start are ignored in IDLE
        adc_valid = 1'b1;
        mag_valid = 1'b1;
        mag_last  = 1'b1;
        step();
        quiet_inputs();
        check_eq("idle_fs", frame_start, 0);
        check_eq("idle_busy", busy, 0);

        // abort wins over start
        start = 1'b1;
        abort = 1'b1;
        step();
        quiet_inputs();
        check_eq("abort_vs_start", busy, 0);

        // single shot, every cycle and every 3rd cycle
        do_start();
        do_frame(0, -1, 1'b0, 1'b0, 1'b0);
        do_start();
        do_frame(1, -1, 1'b0, 1'b0, 1'b0);

        // FFT timeout, then sticky flag until the next start
        do_start();
        do_frame(2, -1, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("to_sticky", timeout_err, 1);
        check_eq("to_idle", busy, 0);
        do_start();
        do_frame(0, -1, 1'b0, 1'b0, 1'b0);

        // continuous mode across three frames, single start
        continuous = 1'b1;
        do_start();
        do_frame(0, -1, 1'b0, 1'b0, 1'b0);
        do_frame(2, -1, 1'b0, 1'b0, 1'b0);
        continuous = 1'b0;
        do_frame(1, -1, 1'b0, 1'b0, 1'b0);

        // abort at the 4th sample_valid, and abort in DONE
        do_start();
        do_frame(0, 4, 1'b0, 1'b0, 1'b0);
        do_start();
        do_frame(2, -1, 1'b1, 1'b0, 1'b0);

        // reset in the middle of SETTLE, then one clean frame
        do_start();
        do_frame(0, -1, 1'b0, 1'b1, 1'b0);
        do_start();
        do_frame(2, -1, 1'b0, 1'b0, 1'b0);

        // random frames
        for (int f = 0; f < 6; f++) begin
            continuous = 1'($urandom);
            do_start();
            do_frame($urandom_range(0, 2), -1, 1'b0, 1'b0, 1'b0);
            if (continuous) begin
                abort = 1'b1;
                step();
                quiet_inputs();
                check_eq("rand_abort_arm", busy, 0);
            end
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/metrics_sequencer.md
# metrics_sequencer

Controls the measurement frame sequence for the signal-metrics datapath. It gates the free-running ADC stream into exactly one metrics frame, then triggers the FFT and waits for its magnitude output. After that it waits for the THD computation to settle and issues a single result strobe. It runs in single-shot or continuous mode, with abort handling and an FFT timeout.

## Interface
- DATA_WIDTH, 12, ADC sample width
- SAMPLE_COUNT, 1024, samples per frame following the frame_start sample
- SETTLE_CYCLES, 520, cycles after magnitude_last before results are valid (covers the THD scan)
- TIMEOUT_CYCLES, 65536, maximum cycles in FFT_WAIT
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; begins a frame from IDLE
- continuous  in  1  when 1, DONE returns to ARM instead of IDLE
- abort  in  1  forces IDLE from any state
- adc_data  in  DATA_WIDTH  raw ADC sample
- adc_valid  in  1  adc_data qualifier
- magnitude_valid  in  1  FFT magnitude strobe (monitored)
- magnitude_last  in  1  last FFT bin (monitored)
- frame_start  out  1  metrics frame start, registered
- sample_data  out  DATA_WIDTH  registered copy of adc_data
- sample_valid  out  1  metrics sample strobe, registered
- fft_start  out  1  one-cycle FFT trigger
- busy  out  1  high whenever state != IDLE
- result_valid  out  1  one-cycle strobe; metrics outputs are stable
- timeout_err  out  1  sticky; set on FFT timeout, cleared by start or rst
- frame_count  out  16  completed frames, wraps at 0xFFFF->0

## Operation
- States: IDLE, ARM, CAPTURE, FFT_WAIT, SETTLE, DONE.
- IDLE: start -> ARM and clear timeout_err. All other inputs are ignored.
- ARM: on the first adc_valid, drive frame_start=1 for one cycle with sample_data=adc_data, load sample counter to 0, and go to CAPTURE. sample_valid stays 0 on this cycle.
- CAPTURE: each adc_valid drives sample_valid=1 with that sample and increments the counter. On the SAMPLE_COUNT-th sample, go to FFT_WAIT. adc_valid cycles arriving outside ARM/CAPTURE are dropped.
- FFT_WAIT, entry cycle: fft_start=1 and the timeout counter is cleared.
  - magnitude_valid && magnitude_last -> SETTLE, with the settle counter cleared.
  - Timeout counter reaches TIMEOUT_CYCLES-1 -> set timeout_err and go to IDLE. No result_valid is issued.
- SETTLE: count SETTLE_CYCLES cycles, then go to DONE.
- DONE: result_valid=1 for one cycle and frame_count increments. Next state is ARM if continuous, otherwise IDLE.
- abort: next state is IDLE from any state and all strobes are 0 on that edge. abort takes priority over start and over every transition, including DONE (no result_valid, no count).
- start while busy: ignored.
- Counters: sample counter is 32-bit, settle counter 16-bit, timeout counter 32-bit. None of them wraps within a frame.

## Timing
- Reset values:
  - state IDLE
  - frame_start, sample_valid, fft_start, result_valid, busy, timeout_err all 0
  - sample_data 0
  - frame_count 0
- Latency: adc_valid in cycle n -> frame_start/sample_valid and sample_data in cycle n+1. Every qualifying sample adds exactly one cycle of latency.
- fft_start: asserted in the cycle after the SAMPLE_COUNT-th sample_valid.
- Result: result_valid asserts SETTLE_CYCLES+1 cycles after the cycle sampling magnitude_last.
- Continuous mode: ARM is entered the cycle after DONE. The first adc_valid seen in ARM starts the next frame.
- busy goes low in the same cycle the state register becomes IDLE.

## Test plan
- Single shot, adc_valid every cycle, SAMPLE_COUNT=8 -> one frame_start, 8 sample_valid, fft_start 1 cycle after the 8th; magnitude_last at T -> result_valid at T+SETTLE_CYCLES+1, frame_count=1, busy low after.
- adc_valid every 3rd cycle -> sample_data matches each input, 8 strobes, no extra or duplicated samples.
- No magnitude_last, TIMEOUT_CYCLES=100 -> timeout_err=1 after 100 cycles in FFT_WAIT, no result_valid, IDLE; next start clears timeout_err.
- continuous=1 across 3 frames -> 3 result_valid strobes, frame_count=3, ARM re-entered with no start.
- abort mid-CAPTURE (4th sample) and abort coincident with DONE -> IDLE next cycle, no fft_start/result_valid, frame_count unchanged.
- start asserted during CAPTURE and rst mid-SETTLE -> start ignored; rst returns all outputs to reset values.
